// File: rtl/onchip_sram_port_arbiter.sv
// Two-master round-robin arbiter in front of one on-chip SRAM port.
// Pass-through command path, bounded owner hold, 1-cycle read return.
module onchip_sram_port_arbiter #(
  parameter int ADDR_W   = 14,
  parameter int DATA_W   = 32,
  parameter int BE_W     = 4,
  parameter int HOLD_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] sram_address,
  output logic [BE_W-1:0]   sram_byteenable,
  output logic              sram_chipselect,
  output logic              sram_write,
  output logic [DATA_W-1:0] sram_writedata,
  output logic              sram_clken,
  input  logic [DATA_W-1:0] sram_readdata
);

  localparam int HC_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [HC_W-1:0] HOLD_LIM = HC_W'(HOLD_MAX - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [HC_W-1:0] hold_q, hold_d;
  logic            last_q, last_d;
  logic            rdv0_q, rdv1_q;
  logic            req0, req1;
  logic            gnt0, gnt1;
  logic [HC_W-1:0] hold_inc;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  assign hold_inc = (hold_q == HOLD_LIM) ? hold_q : hold_q + 1'b1;

  // Grant decision and next owner/hold bookkeeping
  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    state_d = IDLE;
    hold_d  = '0;
    last_d  = last_q;
    if (!reset) begin
      if (req0 && req1) begin
        unique case (state_q)
          OWN0: begin
            if (hold_q < HOLD_LIM) gnt0 = 1'b1;
            else                   gnt1 = 1'b1;
          end
          OWN1: begin
            if (hold_q < HOLD_LIM) gnt1 = 1'b1;
            else                   gnt0 = 1'b1;
          end
          default: begin
            if (last_q) gnt0 = 1'b1;
            else        gnt1 = 1'b1;
          end
        endcase
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
      if (gnt0) begin
        state_d = OWN0;
        last_d  = 1'b0;
        hold_d  = (state_q == OWN0) ? hold_inc : '0;
      end else if (gnt1) begin
        state_d = OWN1;
        last_d  = 1'b1;
        hold_d  = (state_q == OWN1) ? hold_inc : '0;
      end
    end
  end

  // Arbitration state; last starts at m1 so m0 wins the first tie
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
    end
  end

  // Read-valid pulse one cycle after an accepted read (write wins over read)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdv0_q <= 1'b0;
      rdv1_q <= 1'b0;
    end else begin
      rdv0_q <= gnt0 & m0_read & ~m0_write;
      rdv1_q <= gnt1 & m1_read & ~m1_write;
    end
  end

  assign m0_waitrequest = reset | (req0 & ~gnt0);
  assign m1_waitrequest = reset | (req1 & ~gnt1);

  assign m0_readdata      = sram_readdata;
  assign m1_readdata      = sram_readdata;
  assign m0_readdatavalid = rdv0_q;
  assign m1_readdatavalid = rdv1_q;

  assign sram_chipselect = gnt0 | gnt1;
  assign sram_write      = (gnt0 & m0_write) | (gnt1 & m1_write);
  assign sram_address    = gnt1 ? m1_address    : m0_address;
  assign sram_byteenable = gnt1 ? m1_byteenable : m0_byteenable;
  assign sram_writedata  = gnt1 ? m1_writedata  : m0_writedata;
  assign sram_clken      = ~reset;

endmodule

// File: tb/tb_onchip_sram_port_arbiter.sv
// Randomised bench for onchip_sram_port_arbiter with a behavioural
// round-robin / memory model checked every cycle.
module tb_onchip_sram_port_arbiter;

  localparam int ADDR_W   = 14;
  localparam int DATA_W   = 32;
  localparam int BE_W     = 4;
  localparam int HOLD_MAX = 4;
  localparam int DEPTH    = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              reset;
  logic [ADDR_W-1:0] m0_address, m1_address;
  logic [BE_W-1:0]   m0_byteenable, m1_byteenable;
  logic              m0_read, m0_write, m1_read, m1_write;
  logic [DATA_W-1:0] m0_writedata, m1_writedata;
  logic              m0_waitrequest, m1_waitrequest;
  logic [DATA_W-1:0] m0_readdata, m1_readdata;
  logic              m0_readdatavalid, m1_readdatavalid;
  logic [ADDR_W-1:0] sram_address;
  logic [BE_W-1:0]   sram_byteenable;
  logic              sram_chipselect, sram_write, sram_clken;
  logic [DATA_W-1:0] sram_writedata;
  logic [DATA_W-1:0] sram_readdata;

  logic [DATA_W-1:0] sram_mem [DEPTH];
  logic [DATA_W-1:0] shadow   [DEPTH];

  int vectors = 0;
  int miscompares = 0;

  int owner;
  int run;
  int last;
  int mdl_gnt;
  bit pend0, pend1;
  logic [DATA_W-1:0] pend_data;

  onchip_sram_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .HOLD_MAX(HOLD_MAX)
  ) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable),
    .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable),
    .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .sram_address(sram_address), .sram_byteenable(sram_byteenable),
    .sram_chipselect(sram_chipselect), .sram_write(sram_write),
    .sram_writedata(sram_writedata), .sram_clken(sram_clken),
    .sram_readdata(sram_readdata)
  );

  always #5 clk = ~clk;

  // SRAM environment: registered read, byte-lane writes
  always @(posedge clk) begin
    if (sram_chipselect && sram_clken) begin
      if (sram_write) begin
        for (int b = 0; b < BE_W; b++)
          if (sram_byteenable[b])
            sram_mem[sram_address][8*b +: 8] <= sram_writedata[8*b +: 8];
      end else begin
        sram_readdata <= sram_mem[sram_address];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic mdl_reset();
    owner = -1;
    run   = 0;
    last  = 1;
    pend0 = 0;
    pend1 = 0;
  endtask

  // Per-cycle compare against the model, then advance the model
  task automatic check();
    bit r0, r1, wr;
    int g;
    logic [ADDR_W-1:0] a;
    logic [BE_W-1:0] be;
    logic [DATA_W-1:0] wd;
    r0 = m0_read | m0_write;
    r1 = m1_read | m1_write;
    if (reset) begin
      chk("rst_wait0", 32'(m0_waitrequest), 1);
      chk("rst_wait1", 32'(m1_waitrequest), 1);
      chk("rst_cs", 32'(sram_chipselect), 0);
      chk("rst_rdv0", 32'(m0_readdatavalid), 0);
      chk("rst_rdv1", 32'(m1_readdatavalid), 0);
      chk("rst_clken", 32'(sram_clken), 0);
      mdl_reset();
      mdl_gnt = -1;
      return;
    end
    chk("rdv0", 32'(m0_readdatavalid), 32'(pend0));
    chk("rdv1", 32'(m1_readdatavalid), 32'(pend1));
    if (pend0) chk("rdata0", m0_readdata, pend_data);
    if (pend1) chk("rdata1", m1_readdata, pend_data);
    if (r0 && r1) begin
      if (owner >= 0 && run < HOLD_MAX) g = owner;
      else if (owner >= 0)              g = 1 - owner;
      else                              g = 1 - last;
    end else if (r0) g = 0;
    else if (r1)     g = 1;
    else             g = -1;
    wr = (g == 0) ? m0_write : (g == 1) ? m1_write : 1'b0;
    a  = (g == 1) ? m1_address    : m0_address;
    be = (g == 1) ? m1_byteenable : m0_byteenable;
    wd = (g == 1) ? m1_writedata  : m0_writedata;
    chk("wait0", 32'(m0_waitrequest), 32'(r0 && g != 0));
    chk("wait1", 32'(m1_waitrequest), 32'(r1 && g != 1));
    chk("cs", 32'(sram_chipselect), 32'(g >= 0));
    chk("swrite", 32'(sram_write), 32'(wr));
    chk("saddr", 32'(sram_address), 32'(a));
    chk("sbe", 32'(sram_byteenable), 32'(be));
    chk("swdata", sram_writedata, wd);
    chk("clken", 32'(sram_clken), 1);
    pend0 = 0;
    pend1 = 0;
    if (g >= 0) begin
      if (wr) begin
        for (int b = 0; b < BE_W; b++)
          if (be[b]) shadow[a][8*b +: 8] = wd[8*b +: 8];
      end else begin
        pend_data = shadow[a];
        if (g == 0) pend0 = 1;
        else        pend1 = 1;
      end
      if (g == owner) run++;
      else begin
        owner = g;
        run = 1;
      end
      last = g;
    end else begin
      owner = -1;
      run = 0;
    end
    mdl_gnt = g;
  endtask

  task automatic step();
    @(negedge clk);
    check();
    @(posedge clk);
    #1;
  endtask

  task automatic m0_cmd(input bit rd, input bit wr, input int ad,
                        input int be, input logic [31:0] d);
    m0_read = rd;
    m0_write = wr;
    m0_address = ADDR_W'(ad);
    m0_byteenable = BE_W'(be);
    m0_writedata = d;
  endtask

  task automatic m1_cmd(input bit rd, input bit wr, input int ad,
                        input int be, input logic [31:0] d);
    m1_read = rd;
    m1_write = wr;
    m1_address = ADDR_W'(ad);
    m1_byteenable = BE_W'(be);
    m1_writedata = d;
  endtask

  int pat [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};

  initial begin
    int gobs;
    int k;
    for (int i = 0; i < DEPTH; i++) begin
      sram_mem[i] = 32'hC0DE0000 | 32'(i);
      shadow[i]   = 32'hC0DE0000 | 32'(i);
    end
    sram_readdata = '0;
    mdl_reset();
    mdl_gnt = -1;
    reset = 1'b1;
    m0_cmd(0, 0, 0, 0, 0);
    m1_cmd(0, 0, 0, 0, 0);
    repeat (3) step();
    reset = 1'b0;

    // reset release then first read
    m0_cmd(1, 0, 'h10, 'hF, 0);
    step();
    m0_cmd(0, 0, 0, 0, 0);
    chk("t1_rdv", 32'(m0_readdatavalid), 1);
    chk("t1_data", m0_readdata, 32'hC0DE0010);
    step();

    // solo write then read
    m0_cmd(0, 1, 'h100, 'hF, 32'hDEADBEEF);
    #1 chk("t2_wwait", 32'(m0_waitrequest), 0);
    step();
    m0_cmd(1, 0, 'h100, 'hF, 0);
    #1 chk("t2_rwait", 32'(m0_waitrequest), 0);
    step();
    m0_cmd(0, 0, 0, 0, 0);
    chk("t2_data", m0_readdata, 32'hDEADBEEF);
    step();

    // make last = m1, then contention from IDLE
    m1_cmd(1, 0, 1, 'hF, 0);
    step();
    m1_cmd(0, 0, 0, 0, 0);
    step();
    for (int i = 0; i < 12; i++) begin
      m0_cmd(1, 0, 'h20 + i, 'hF, 0);
      m1_cmd(1, 0, 'h40 + i, 'hF, 0);
      #1 gobs = m0_waitrequest ? 1 : 0;
      chk("t3_gnt", 32'(gobs), 32'(pat[i]));
      step();
    end
    m0_cmd(0, 0, 0, 0, 0);
    m1_cmd(0, 0, 0, 0, 0);
    step();

    // byte enables
    m1_cmd(0, 1, 'h2000, 'hF, 32'hFFFFFFFF);
    step();
    m1_cmd(0, 1, 'h2000, 'h5, 32'h11223344);
    step();
    m1_cmd(1, 0, 'h2000, 'hF, 0);
    step();
    m1_cmd(0, 0, 0, 0, 0);
    chk("t4_data", m1_readdata, 32'hFF22FF44);
    step();

    // read+write together is a write
    m0_cmd(1, 1, 'h3, 'hF, 32'hA5A5A5A5);
    step();
    m0_cmd(0, 0, 0, 0, 0);
    chk("t5_rdv", 32'(m0_readdatavalid), 0);
    step();
    m0_cmd(1, 0, 'h3, 'hF, 0);
    step();
    m0_cmd(0, 0, 0, 0, 0);
    chk("t5_data", m0_readdata, 32'hA5A5A5A5);
    step();

    // reset during a read
    m0_cmd(1, 0, 'h5, 'hF, 0);
    step();
    reset = 1'b1;
    m0_cmd(0, 0, 0, 0, 0);
    #1 chk("t6_rdv", 32'(m0_readdatavalid), 0);
    step();
    reset = 1'b0;
    m0_cmd(1, 0, 'h6, 'hF, 0);
    m1_cmd(1, 0, 'h7, 'hF, 0);
    #1 chk("t6_w0", 32'(m0_waitrequest), 0);
    chk("t6_w1", 32'(m1_waitrequest), 1);
    step();
    m0_cmd(0, 0, 0, 0, 0);
    m1_cmd(0, 0, 0, 0, 0);
    step();

    // random traffic; stalled masters hold their command
    for (int c = 0; c < 400; c++) begin
      if (!((m0_read | m0_write) && mdl_gnt != 0)) begin
        k = $urandom_range(0, 4);
        m0_cmd(k == 1 || k == 3 || k == 4, k == 2 || k == 4,
               $urandom_range(0, 15), $urandom_range(0, 15), $urandom);
        if (k == 3) m0_read = 1;
      end
      if (!((m1_read | m1_write) && mdl_gnt != 1)) begin
        k = $urandom_range(0, 4);
        m1_cmd(k == 1 || k == 3, k == 2 || k == 4,
               $urandom_range(0, 15), $urandom_range(0, 15), $urandom);
      end
      if (c == 250) reset = 1'b1;
      if (c == 252) reset = 1'b0;
      step();
    end
    m0_cmd(0, 0, 0, 0, 0);
    m1_cmd(0, 0, 0, 0, 0);
    repeat (2) step();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
